// File: rtl/spram_loader_pkg.sv
// Shared encodings for spram_loader: command modes and controller states.
package spram_loader_pkg;

    localparam logic [1:0] MODE_LOAD   = 2'b00;
    localparam logic [1:0] MODE_FILL   = 2'b01;
    localparam logic [1:0] MODE_VERIFY = 2'b10;
    localparam logic [1:0] MODE_RSVD   = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StFill,
        StVerify,
        StDrain,
        StDone
    } state_e;

endpackage

// File: rtl/spram_loader.sv
// Sequential initiator for a single-port RAM: loads a stream, fills a constant, or
// reads a region back and compares its sum with the checksum of the last write pass.
module spram_loader
    import spram_loader_pkg::*;
#(
    parameter int unsigned AddressWidth = 8,
    parameter int unsigned DataWidth    = 8,
    parameter int unsigned SumWidth     = 16
) (
    input  logic                    i_clock,
    input  logic                    i_reset_n,
    input  logic                    i_start,
    input  logic [1:0]              i_mode,
    input  logic [AddressWidth-1:0] i_base_addr,
    input  logic [AddressWidth:0]   i_length,
    input  logic [DataWidth-1:0]    i_fill_value,
    input  logic [DataWidth-1:0]    i_s_data,
    input  logic                    i_s_valid,
    output logic                    o_s_ready,
    output logic [AddressWidth-1:0] o_ram_address,
    output logic [DataWidth-1:0]    o_ram_data,
    output logic                    o_ram_wren,
    input  logic [DataWidth-1:0]    i_ram_q,
    output logic                    o_busy,
    output logic                    o_done,
    output logic [SumWidth-1:0]     o_checksum,
    output logic                    o_verify_error
);

    localparam logic [AddressWidth-1:0] AddrOne = 1;
    localparam logic [AddressWidth:0]   RemOne  = 1;

    state_e                  r_state;
    logic [AddressWidth-1:0] r_addr;
    logic [AddressWidth:0]   r_remaining;
    logic [DataWidth-1:0]    r_fill_value;
    logic [SumWidth-1:0]     r_checksum;
    logic [SumWidth-1:0]     r_verify_sum;
    logic                    r_addr_vld;
    logic                    r_q_vld;
    logic [AddressWidth-1:0] r_ram_address;
    logic [DataWidth-1:0]    r_ram_data;
    logic                    r_ram_wren;
    logic                    r_done;
    logic                    r_verify_error;

    logic                    w_remaining_zero;
    logic                    w_s_ready;
    logic [SumWidth-1:0]     w_verify_sum_next;

    assign w_remaining_zero  = (r_remaining == '0);
    assign w_s_ready         = (r_state == StLoad) && !w_remaining_zero;
    // r_q_vld marks the cycle in which ram_q belongs to an address we issued
    assign w_verify_sum_next = r_q_vld ? (r_verify_sum + SumWidth'(i_ram_q)) : r_verify_sum;

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state        <= StIdle;
            r_addr         <= '0;
            r_remaining    <= '0;
            r_fill_value   <= '0;
            r_checksum     <= '0;
            r_verify_sum   <= '0;
            r_addr_vld     <= 1'b0;
            r_q_vld        <= 1'b0;
            r_ram_address  <= '0;
            r_ram_data     <= '0;
            r_ram_wren     <= 1'b0;
            r_done         <= 1'b0;
            r_verify_error <= 1'b0;
        end else begin
            r_ram_wren   <= 1'b0;
            r_done       <= 1'b0;
            r_addr_vld   <= 1'b0;
            r_q_vld      <= r_addr_vld;
            r_verify_sum <= w_verify_sum_next;

            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_addr         <= i_base_addr;
                        r_remaining    <= i_length;
                        r_fill_value   <= i_fill_value;
                        r_verify_error <= 1'b0;
                        if (i_mode == MODE_LOAD || i_mode == MODE_FILL) begin
                            r_checksum <= '0;
                        end
                        if (i_mode == MODE_VERIFY) begin
                            r_verify_sum <= '0;
                        end
                        if (i_length == '0 || i_mode == MODE_RSVD) begin
                            r_state <= StDone;
                            r_done  <= 1'b1;
                        end else if (i_mode == MODE_LOAD) begin
                            r_state <= StLoad;
                        end else if (i_mode == MODE_FILL) begin
                            r_state <= StFill;
                        end else begin
                            r_state <= StVerify;
                        end
                    end
                end
                StLoad: begin
                    if (w_remaining_zero) begin
                        r_state <= StDone;
                        r_done  <= 1'b1;
                    end else if (i_s_valid) begin
                        r_ram_address <= r_addr;
                        r_ram_data    <= i_s_data;
                        r_ram_wren    <= 1'b1;
                        r_checksum    <= r_checksum + SumWidth'(i_s_data);
                        r_addr        <= r_addr + AddrOne;
                        r_remaining   <= r_remaining - RemOne;
                    end
                end
                StFill: begin
                    if (w_remaining_zero) begin
                        r_state <= StDone;
                        r_done  <= 1'b1;
                    end else begin
                        r_ram_address <= r_addr;
                        r_ram_data    <= r_fill_value;
                        r_ram_wren    <= 1'b1;
                        r_checksum    <= r_checksum + SumWidth'(r_fill_value);
                        r_addr        <= r_addr + AddrOne;
                        r_remaining   <= r_remaining - RemOne;
                    end
                end
                StVerify: begin
                    if (w_remaining_zero) begin
                        r_state <= StDrain;
                    end else begin
                        r_ram_address <= r_addr;
                        r_addr_vld    <= 1'b1;
                        r_addr        <= r_addr + AddrOne;
                        r_remaining   <= r_remaining - RemOne;
                    end
                end
                StDrain: begin
                    // Last read word arrives now; compare using the sum that includes it
                    r_state        <= StDone;
                    r_done         <= 1'b1;
                    r_verify_error <= (w_verify_sum_next != r_checksum);
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_s_ready      = w_s_ready;
    assign o_ram_address  = r_ram_address;
    assign o_ram_data     = r_ram_data;
    assign o_ram_wren     = r_ram_wren;
    assign o_busy         = (r_state != StIdle);
    assign o_done         = r_done;
    assign o_checksum     = r_checksum;
    assign o_verify_error = r_verify_error;

endmodule

// File: tb/tb_spram_loader.sv
// Bench for spram_loader: drives commands into a behavioural RAM and compares the observed
// write stream, RAM contents, checksum and verify result with a region-level reference.
module tb_spram_loader;
    import spram_loader_pkg::*;

    localparam int AW    = 8;
    localparam int DW    = 8;
    localparam int SW    = 16;
    localparam int DEPTH = 1 << AW;
    localparam int SMOD  = 1 << SW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          start;
    logic [1:0]    mode;
    logic [AW-1:0] base;
    logic [AW:0]   len;
    logic [DW-1:0] fill;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic [AW-1:0] dut_addr;
    logic [DW-1:0] dut_data;
    logic          dut_wren;
    logic [DW-1:0] ram_q;
    logic          busy;
    logic          done;
    logic [SW-1:0] checksum;
    logic          verify_error;

    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_data;
    logic          core_wren;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_data;
    logic          ram_wren;

    spram_loader #(
        .AddressWidth (AW),
        .DataWidth    (DW),
        .SumWidth     (SW)
    ) dut (
        .i_clock        (clk),
        .i_reset_n      (rst_n),
        .i_start        (start),
        .i_mode         (mode),
        .i_base_addr    (base),
        .i_length       (len),
        .i_fill_value   (fill),
        .i_s_data       (s_data),
        .i_s_valid      (s_valid),
        .o_s_ready      (s_ready),
        .o_ram_address  (dut_addr),
        .o_ram_data     (dut_data),
        .o_ram_wren     (dut_wren),
        .i_ram_q        (ram_q),
        .o_busy         (busy),
        .o_done         (done),
        .o_checksum     (checksum),
        .o_verify_error (verify_error)
    );

    // Core port owns the RAM while the loader is idle
    assign ram_addr = busy ? dut_addr : core_addr;
    assign ram_data = busy ? dut_data : core_data;
    assign ram_wren = busy ? dut_wren : core_wren;

    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_wren) mem[ram_addr] <= ram_data;
        ram_q <= mem[ram_addr];
    end

    // Reference: RAM image and checksum of the last write pass
    int            ref_mem [DEPTH];
    int            ref_sum = 0;
    logic [DW-1:0] stream_q[$];

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;

    wr_t wr_q[$];
    int  done_q[$];
    int  cyc = 0;
    int  bad_wren = 0;
    bit  hs_prev = 1'b0;
    bit  chk_hs = 1'b0;

    int  wr0, done0, bad0, extra_ready, lat;
    bit  ve_at_done;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (dut_wren) wr_q.push_back('{int'(dut_addr), int'(dut_data), cyc});
        if (done) done_q.push_back(cyc);
        if (dut_wren && chk_hs && !hs_prev) bad_wren <= bad_wren + 1;
        hs_prev <= s_ready && s_valid;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int region_sum(input int b, input int l);
        int s = 0;
        for (int i = 0; i < l; i++) s = (s + ref_mem[(b + i) % DEPTH]) % SMOD;
        return s;
    endfunction

    task automatic model_write(input int b, input int l, input bit is_fill, input int f);
        int d;
        ref_sum = 0;
        for (int i = 0; i < l; i++) begin
            d = is_fill ? f : int'(stream_q[i]);
            ref_mem[(b + i) % DEPTH] = d;
            ref_sum = (ref_sum + d) % SMOD;
        end
    endtask

    task automatic run_cmd(input string tag, input logic [1:0] m, input int b, input int l,
                           input int f, input int stall, input bit spam);
        bit hs;
        bit seen = 1'b0;
        int idx = 0;
        wr0 = wr_q.size();
        done0 = done_q.size();
        bad0 = bad_wren;
        extra_ready = 0;
        lat = -1;
        chk_hs = (m == MODE_LOAD);
        mode  = m;
        base  = b[AW-1:0];
        len   = l[AW:0];
        fill  = f[DW-1:0];
        start = 1'b1;
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            if (m == MODE_LOAD && idx < stream_q.size()) begin
                if (stall == 0) s_valid = 1'b1;
                else if (stall == 1) s_valid = (c % 2 == 0);
                else s_valid = 1'($urandom_range(0, 1));
            end else begin
                s_valid = 1'b0;
            end
            s_data = s_valid ? stream_q[idx] : DW'($urandom);
            if (spam) begin
                start = 1'b1;
                mode  = MODE_LOAD;
                base  = AW'($urandom);
                len   = 9'd7;
            end
            @(negedge clk);
            hs = s_ready && s_valid;
            if (m == MODE_LOAD && idx >= stream_q.size() && s_ready) extra_ready++;
            if (done) begin
                seen = 1'b1;
                lat = c;
                ve_at_done = verify_error;
            end
            @(posedge clk);
            #1;
            if (hs) idx++;
        end
        start = 1'b0;
        s_valid = 1'b0;
        if (!seen) check_eq({tag, "_done_timeout"}, 0, 1);
        @(negedge clk);
        check_eq({tag, "_done_width"}, {done, busy}, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_writes(input string tag, input int b, input int n, input bit is_fill,
                                input int f);
        int bad = 0;
        int nw = wr_q.size() - wr0;
        int d;
        check_eq({tag, "_wr_count"}, nw, n);
        for (int i = 0; i < nw && i < n; i++) begin
            d = is_fill ? f : int'(stream_q[i]);
            if (wr_q[wr0 + i].addr != (b + i) % DEPTH || wr_q[wr0 + i].data != d) bad++;
            if (is_fill && wr_q[wr0 + i].cyc != wr_q[wr0].cyc + i) bad++;
        end
        check_eq({tag, "_wr_content"}, bad, 0);
        if (nw > 0 && done_q.size() > done0)
            check_eq({tag, "_done_after_wr"}, done_q[done0], wr_q[wr_q.size() - 1].cyc + 1);
        check_eq({tag, "_checksum"}, checksum, ref_sum);
    endtask

    task automatic check_mem(input string tag, input int b, input int l);
        int bad = 0;
        for (int i = 0; i < l; i++)
            if (mem[(b + i) % DEPTH] !== DW'(ref_mem[(b + i) % DEPTH])) bad++;
        check_eq(tag, bad, 0);
    endtask

    task automatic core_write(input int a, input int d);
        core_addr = a[AW-1:0];
        core_data = d[DW-1:0];
        core_wren = 1'b1;
        @(posedge clk);
        #1;
        core_wren = 1'b0;
        ref_mem[a % DEPTH] = d;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_ctl"}, {dut_wren, s_ready, busy, done, verify_error}, 0);
        check_eq({tag, "_addr_data"}, {dut_addr, dut_data}, 0);
        check_eq({tag, "_checksum"}, checksum, 0);
    endtask

    initial begin
        int b, l, f, vb, vl;
        rst_n = 1'b0;
        start = 1'b0;
        mode = MODE_LOAD;
        base = '0;
        len = '0;
        fill = '0;
        s_data = '0;
        s_valid = 1'b0;
        core_addr = '0;
        core_data = '0;
        core_wren = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        #1;

        // Load across the top of the address space
        stream_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_cmd("load", MODE_LOAD, 'hFE, 4, 0, 0, 1'b0);
        model_write('hFE, 4, 1'b0, 0);
        check_writes("load", 'hFE, 4, 1'b0, 0);
        check_eq("load_sum_value", checksum, 'hAA);
        check_eq("load_latency", lat, 5);
        check_eq("load_wren_hs", bad_wren - bad0, 0);
        check_mem("load_mem", 'hFE, 4);

        run_cmd("load_tog", MODE_LOAD, 'hFE, 4, 0, 1, 1'b0);
        model_write('hFE, 4, 1'b0, 0);
        check_writes("load_tog", 'hFE, 4, 1'b0, 0);
        check_eq("load_tog_wren_hs", bad_wren - bad0, 0);
        check_eq("load_tog_ready_after", extra_ready, 0);
        check_mem("load_tog_mem", 'hFE, 4);

        // Whole-RAM fill
        run_cmd("fill", MODE_FILL, 0, 256, 'hA5, 0, 1'b0);
        model_write(0, 256, 1'b1, 'hA5);
        check_writes("fill", 0, 256, 1'b1, 'hA5);
        check_eq("fill_sum_value", checksum, 'hA500);
        check_eq("fill_latency", lat, 257);
        check_mem("fill_mem", 0, 256);

        run_cmd("verify", MODE_VERIFY, 0, 256, 0, 0, 1'b0);
        check_eq("verify_err", ve_at_done, 32'(region_sum(0, 256) != ref_sum));
        check_eq("verify_no_wr", wr_q.size() - wr0, 0);
        check_eq("verify_latency", lat, 258);
        check_eq("verify_sum_kept", checksum, ref_sum);

        core_write('h10, 'h00);
        run_cmd("verify_bad", MODE_VERIFY, 0, 256, 0, 0, 1'b0);
        check_eq("verify_bad_err", ve_at_done, 32'(region_sum(0, 256) != ref_sum));
        check_eq("verify_bad_expect", ve_at_done, 1);

        // Zero length and reserved mode complete immediately
        run_cmd("len0", MODE_VERIFY, 5, 0, 0, 0, 1'b0);
        check_eq("len0_latency", lat, 0);
        check_eq("len0_no_wr", wr_q.size() - wr0, 0);
        check_eq("len0_sum_kept", checksum, ref_sum);
        run_cmd("rsvd", MODE_RSVD, 3, 10, 'h77, 0, 1'b0);
        check_eq("rsvd_latency", lat, 0);
        check_eq("rsvd_no_wr", wr_q.size() - wr0, 0);
        check_eq("rsvd_sum_kept", checksum, ref_sum);

        // Reset in the middle of a fill
        mode = MODE_FILL;
        base = '0;
        len = 9'd256;
        fill = 8'h3C;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wr0 = wr_q.size();
        @(negedge clk);
        check_idle_outputs("midreset");
        repeat (5) @(posedge clk);
        #1;
        check_eq("midreset_no_wr", wr_q.size() - wr0, 0);

        run_cmd("fill_spam", MODE_FILL, 'h40, 256, 'h5A, 0, 1'b1);
        model_write('h40, 256, 1'b1, 'h5A);
        check_writes("fill_spam", 'h40, 256, 1'b1, 'h5A);
        check_mem("fill_spam_mem", 0, 256);

        // Randomised loads, fills and verifies
        for (int it = 0; it < 10; it++) begin
            b = $urandom_range(0, DEPTH - 1);
            l = $urandom_range(1, 40);
            if (it % 3 == 2) begin
                f = $urandom_range(0, 255);
                run_cmd("rnd_fill", MODE_FILL, b, l, f, 0, 1'b0);
                model_write(b, l, 1'b1, f);
                check_writes("rnd_fill", b, l, 1'b1, f);
            end else begin
                stream_q.delete();
                for (int i = 0; i < l; i++) stream_q.push_back(DW'($urandom));
                run_cmd("rnd_load", MODE_LOAD, b, l, 0, 2, 1'b0);
                model_write(b, l, 1'b0, 0);
                check_writes("rnd_load", b, l, 1'b0, 0);
                check_eq("rnd_load_wren_hs", bad_wren - bad0, 0);
                check_eq("rnd_load_ready_after", extra_ready, 0);
            end
            check_mem("rnd_mem", b, l);
            if (it % 2 == 1) core_write($urandom_range(0, DEPTH - 1), $urandom_range(0, 255));
            vb = (it % 4 == 0) ? b : $urandom_range(0, DEPTH - 1);
            vl = (it % 4 == 0) ? l : $urandom_range(1, 64);
            run_cmd("rnd_verify", MODE_VERIFY, vb, vl, 0, 0, 1'b0);
            check_eq("rnd_verify_err", ve_at_done, 32'(region_sum(vb, vl) != ref_sum));
            check_eq("rnd_verify_sum_kept", checksum, ref_sum);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spram_loader.md
Name: spram_loader

Overview:
- Initiator/writer for the team's generic single-port RAM: drives its address/data/wren port and consumes its registered read data.
- Three jobs:
  - load a byte stream from the download/ROM-loader path into RAM at sequential addresses;
  - fill a region with a constant (power-up or game-reset clear of work RAM);
  - read a region back and compare its checksum against the one accumulated on the last write pass.
- Sits between the host download logic / reset sequencer and one RAM instance; the core's own RAM port is muxed in only while busy is low.

Parameters:
- address_width, 8, RAM address bits; equals the RAM's address_width.
- data_width, 8, RAM word bits; equals the RAM's data_width.
- sum_width, 16, checksum accumulator width; sum is modulo 2^sum_width.

Ports:
- clock  in  1  single system clock; all logic on rising edge.
- reset_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle command strobe; sampled only in IDLE.
- mode  in  2  command: 00 load, 01 fill, 10 verify, 11 reserved (treated as no-op, done pulses).
- base_addr  in  address_width  first RAM address; sampled on start.
- length  in  address_width+1  word count, 0..2^address_width; sampled on start.
- fill_value  in  data_width  constant for fill; sampled on start.
- s_data  in  data_width  stream word for load.
- s_valid  in  1  stream word present.
- s_ready  out  1  loader accepts stream word this cycle.
- ram_address  out  address_width  to RAM address.
- ram_data  out  data_width  to RAM data.
- ram_wren  out  1  to RAM wren.
- ram_q  in  data_width  from RAM q; valid one cycle after ram_address is presented.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when a command completes.
- checksum  out  sum_width  sum of words written by the last load/fill.
- verify_error  out  1  sticky result of last verify; cleared on next accepted start.

Behaviour:
- Reset (reset_n low at an edge): state IDLE. ram_wren, s_ready, busy, done, verify_error, ram_address, ram_data and checksum all 0. Reset mid-operation aborts with no further writes; ram_wren is 0 in the cycle after the reset edge.
- States: IDLE, LOAD, FILL, VERIFY, DRAIN, DONE.
- IDLE:
  - start=1 latches base_addr, length and fill_value into addr/remaining counters and clears verify_error.
  - load and fill also clear the checksum accumulator; verify clears a separate verify accumulator.
  - Next state by mode: LOAD, FILL or VERIFY. If length=0 or mode=11, next state is DONE.
  - start while busy is ignored.
- All RAM outputs are registered:
  - LOAD: s_ready = (state==LOAD && remaining!=0).
    - On s_valid&&s_ready at cycle n: cycle n+1 drives ram_address=addr, ram_data=s_data, ram_wren=1; checksum += s_data; addr++; remaining--.
    - When remaining reaches 0, next state is DONE.
    - Stalls (s_valid=0) insert idle cycles with ram_wren=0.
  - FILL: one write per cycle, ram_data=fill_value, no stall; checksum += fill_value each write. Takes exactly length cycles, then DONE.
  - VERIFY: issues one read address per cycle with ram_wren=0. ram_q captured for address k arrives the cycle after that address is driven and is added to the verify accumulator. After the last address, DRAIN (one cycle) absorbs the final ram_q.
- Address wraps modulo 2^address_width from base_addr. length=2^address_width covers the whole RAM exactly once.
- DONE:
  - done=1 for one cycle; ram_wren=0; return to IDLE.
  - For verify, verify_error = (verify accumulator != checksum), registered with done.
- checksum holds until the next load/fill start; verify never modifies it.
- ram_wren is never high outside LOAD/FILL write cycles.

Decomposition:
- Shared package: mode encodings (MODE_LOAD, MODE_FILL, MODE_VERIFY) and the state enumeration.
- No sub-module required. An optional stream skid buffer is not needed because s_ready is combinational on state/remaining only.

Test Plan:
- Load, aw=8: base=0xFE, length=4, stream 0x11,0x22,0x33,0x44 with no stalls → writes to 0xFE,0xFF,0x00,0x01; checksum=0x00AA; done 1 cycle after last write; RAM readback matches.
- Load with s_valid toggling every other cycle → same writes, ram_wren only in cycles following a handshake, s_ready low after the 4th word.
- Fill: base=0x00, length=256, fill_value=0xA5 → exactly 256 consecutive ram_wren cycles; checksum=0xA500; every RAM word reads 0xA5.
- Verify after fill → done with verify_error=0. Then corrupt address 0x10 to 0x00 via the core port and verify again → verify_error=1.
- length=0 and mode=11 → done pulses the cycle after start, no ram_wren, checksum unchanged.
- reset_n low for one cycle midway through a 256-word fill → ram_wren=0 the next cycle, all outputs 0, state IDLE. A later start is accepted normally; start pulses during busy are ignored.
